// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update bundle between the core pipeline and the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned IDX_W = 6
);
  logic [31:0]      if_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [IDX_W-1:0] pred_bht_idx;

  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_is_b_type;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_pred_taken;
  logic [31:0]      upd_pred_target;
  logic [IDX_W-1:0] upd_bht_idx;

  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [31:0]      mispredict_count;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_is_b_type, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, upd_bht_idx,
    input  pred_taken, pred_target, pred_bht_idx, mispredict, redirect_pc, mispredict_count
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_is_b_type, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, upd_bht_idx,
    output pred_taken, pred_target, pred_bht_idx, mispredict, redirect_pc, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating BHT + direct-mapped BTB branch predictor with mispredict detection.
// Optional gshare indexing of the lookup path is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned GHR_BITS    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);
  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned BTB_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - BTB_W;

  if (GHR_BITS > IDX_W) begin : g_bad_ghr
    $error("GHR_BITS must not exceed log2(BHT_ENTRIES)");
  end

  logic [1:0]             bht_q     [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_vld_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [31:0]            count_q;

  logic [BTB_W-1:0] lkp_btb_i;
  logic [IDX_W-1:0] lkp_idx;
  logic             lkp_hit;
  logic             lkp_taken;
  logic [BTB_W-1:0] upd_btb_i;
  logic             br_mis;
  logic             mis;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  // History shifts on every resolved conditional branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (bp.upd_valid && bp.upd_is_b_type) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], bp.upd_taken};
    end
  end

  assign lkp_idx = bp.if_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
  assign lkp_idx = bp.if_pc[IDX_W+1:2];
`endif

  // Fetch-side lookup: reads pre-update state, no bypass from the update port.
  always_comb begin
    lkp_btb_i = bp.if_pc[BTB_W+1:2];
    lkp_hit   = btb_vld_q[lkp_btb_i] && (btb_tag_q[lkp_btb_i] == bp.if_pc[31:BTB_W+2]);
    lkp_taken = lkp_hit && bht_q[lkp_idx][1];
    bp.pred_taken   = lkp_taken;
    bp.pred_bht_idx = lkp_idx;
    bp.pred_target  = lkp_taken ? btb_tgt_q[lkp_btb_i] : 32'(bp.if_pc + 32'd4);
  end

  // Execute-side resolution: a non-branch is only wrong if fetch redirected on it.
  always_comb begin
    upd_btb_i = bp.upd_pc[BTB_W+1:2];
    br_mis    = (bp.upd_taken != bp.upd_pred_taken) ||
                (bp.upd_taken && bp.upd_pred_taken && (bp.upd_target != bp.upd_pred_target));
    mis       = bp.upd_valid && (bp.upd_is_b_type ? br_mis : bp.upd_pred_taken);
    bp.mispredict  = mis;
    bp.redirect_pc = (bp.upd_is_b_type && bp.upd_taken) ? bp.upd_target
                                                        : 32'(bp.upd_pc + 32'd4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bp.upd_valid && bp.upd_is_b_type) begin
      if (bp.upd_taken && (bht_q[bp.upd_bht_idx] != 2'b11)) begin
        bht_q[bp.upd_bht_idx] <= 2'(bht_q[bp.upd_bht_idx] + 2'd1);
      end else if (!bp.upd_taken && (bht_q[bp.upd_bht_idx] != 2'b00)) begin
        bht_q[bp.upd_bht_idx] <= 2'(bht_q[bp.upd_bht_idx] - 2'd1);
      end
    end
  end

  // Taken branches allocate over any occupant; a redirected non-branch drops its stale entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld_q <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else if (bp.upd_valid) begin
      if (bp.upd_is_b_type && bp.upd_taken) begin
        btb_vld_q[upd_btb_i] <= 1'b1;
        btb_tag_q[upd_btb_i] <= bp.upd_pc[31:BTB_W+2];
        btb_tgt_q[upd_btb_i] <= bp.upd_target;
      end else if (!bp.upd_is_b_type && bp.upd_pred_taken) begin
        btb_vld_q[upd_btb_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (mis && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= 32'(count_q + 32'd1);
    end
  end

  assign bp.mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then randomized pipeline traffic.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  branch_predictor_if #(.IDX_W(6)) bp ();

  branch_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptg;
    logic [5:0]  idx;
    logic        mis;
    logic [31:0] rpc;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic [5:0]  idx;
  } infl_t;

  exp_t  exp_q[$];
  infl_t infl_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state, kept in plain integer form.
  int          bht_m [64];
  bit          bv_m  [16];
  logic [31:0] btag_m[16];
  logic [31:0] btgt_m[16];
  logic [31:0] cnt_m;
  int          ghr_m;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    for (int i = 0; i < 16; i++) begin
      bv_m[i] = 0; btag_m[i] = 0; btgt_m[i] = 0;
    end
    cnt_m = 0;
    ghr_m = 0;
  endfunction

  function automatic void predict(input logic [31:0] pc, output logic t,
                                  output logic [31:0] tg, output logic [5:0] idx);
    int bi, ix;
    bit hit;
    ix = (pc >> 2) % 64;
`ifdef BP_GSHARE_EN
    ix = ix ^ ghr_m;
`endif
    bi  = (pc >> 2) % 16;
    hit = bv_m[bi] && (btag_m[bi] == (pc >> 6));
    t   = hit && (bht_m[ix] >= 2);
    tg  = t ? btgt_m[bi] : pc + 32'd4;
    idx = 6'(ix);
  endfunction

  function automatic bit model_mis(input bit uv, input bit isb, input bit tk,
                                   input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    if (!uv) return 0;
    if (isb) return (tk != ptk) || (tk && ptk && tgt != ptgt);
    return ptk;
  endfunction

  function automatic void model_train(input logic [31:0] upc, input bit isb, input bit tk,
                                      input logic [31:0] tgt, input logic [5:0] pidx, input bit mis);
    int bi;
    bi = (upc >> 2) % 16;
    if (isb) begin
      if (tk) bht_m[pidx] = (bht_m[pidx] == 3) ? 3 : bht_m[pidx] + 1;
      else    bht_m[pidx] = (bht_m[pidx] == 0) ? 0 : bht_m[pidx] - 1;
      ghr_m = ((ghr_m << 1) | int'(tk)) & 63;
      if (tk) begin
        bv_m[bi] = 1; btag_m[bi] = upc >> 6; btgt_m[bi] = tgt;
      end
    end else if (bp.upd_pred_taken) begin
      bv_m[bi] = 0;
    end
    if (mis && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
  endfunction

  // One cycle: drive at negedge, push expectation, then account for the rising edge.
  task automatic step(input string nm, input logic [31:0] pc, input bit uv,
                      input logic [31:0] upc, input bit isb, input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt, input logic [5:0] pidx,
                      input bit rst_mid);
    exp_t e;
    bit   m;
    @(negedge clk);
    bp.if_pc = pc;           bp.upd_valid = uv;       bp.upd_pc = upc;
    bp.upd_is_b_type = isb;  bp.upd_taken = tk;       bp.upd_target = tgt;
    bp.upd_pred_taken = ptk; bp.upd_pred_target = ptgt; bp.upd_bht_idx = pidx;
    e.name = nm;
    predict(pc, e.pt, e.ptg, e.idx);
    m     = model_mis(uv, isb, tk, tgt, ptk, ptgt);
    e.mis = m;
    e.rpc = (isb && tk) ? tgt : upc + 32'd4;
    e.cnt = cnt_m;
    exp_q.push_back(e);
    if (rst_mid) begin
      #4 rst_n = 1'b0;
      model_reset();
    end
    @(posedge clk);
    if (rst_n && uv) model_train(upc, isb, tk, tgt, pidx, m);
    #1 bp.upd_valid = 1'b0;
  endtask

  // Update whose carried fetch fields come from the model's current prediction for upc.
  task automatic resolve(input string nm, input logic [31:0] pc, input logic [31:0] upc,
                         input bit isb, input bit tk, input logic [31:0] tgt, input bit rst_mid);
    logic        ptk;
    logic [31:0] ptgt;
    logic [5:0]  pidx;
    predict(upc, ptk, ptgt, pidx);
    step(nm, pc, 1'b1, upc, isb, tk, tgt, ptk, ptgt, pidx, rst_mid);
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc);
    step(nm, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver has settled the inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".pred_taken"},  32'(bp.pred_taken),   32'(e.pt));
        chk({e.name, ".pred_target"}, bp.pred_target,       e.ptg);
        chk({e.name, ".bht_idx"},     32'(bp.pred_bht_idx), 32'(e.idx));
        chk({e.name, ".mispredict"},  32'(bp.mispredict),   32'(e.mis));
        if (e.mis) chk({e.name, ".redirect_pc"}, bp.redirect_pc, e.rpc);
        chk({e.name, ".count"},       bp.mispredict_count,  e.cnt);
      end
    end
  end

  logic [31:0] pc_pool  [8];
  logic [31:0] tgt_pool [4];

  initial begin
    infl_t       f;
    logic        pt;
    logic [31:0] ptg;
    logic [5:0]  idx;
    logic [31:0] lpc;
    int          wait_cyc;

    pc_pool  = '{32'h100, 32'h140, 32'h200, 32'h104, 32'h3F0, 32'h10C, 32'hFFFF_FFFC, 32'h180};
    tgt_pool = '{32'h80, 32'h200, 32'h3F0, 32'h1000};

    rst_n = 1'b0;
    bp.if_pc = 32'h100;    bp.upd_valid = 1'b0;   bp.upd_pc = '0;
    bp.upd_is_b_type = 1'b0; bp.upd_taken = 1'b0; bp.upd_target = '0;
    bp.upd_pred_taken = 1'b0; bp.upd_pred_target = '0; bp.upd_bht_idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lookup("reset_lookup", 32'h100);
    resolve("first_taken", 32'h100, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    lookup("trained_lookup", 32'h100);
    repeat (3) resolve("taken_again", 32'h100, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    resolve("not_taken", 32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    lookup("after_nt", 32'h100);
    resolve("nonbranch_redirect", 32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("after_invalidate", 32'h100);

    resolve("retrain", 32'h100, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    resolve("reset_mid_update", 32'h100, 32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
    lookup("in_reset", 32'h100);
    @(negedge clk) rst_n = 1'b1;
    lookup("post_reset", 32'h100);

    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    cnt_m = 32'hFFFF_FFFF;
    resolve("sat_mispredict", 32'h100, 32'h100, 1'b1, 1'b1, 32'h300, 1'b0);
    lookup("wrap_lookup", 32'hFFFF_FFFC);

    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Randomized traffic: updates carry predictions made a few cycles earlier.
    for (int it = 0; it < 400; it++) begin
      lpc = pc_pool[$urandom_range(0, 7)];
      predict(lpc, pt, ptg, idx);
      infl_q.push_back('{lpc, pt, ptg, idx});
      if (infl_q.size() > 2 && $urandom_range(0, 3) != 0) begin
        f = infl_q.pop_front();
        if ($urandom_range(0, 15) == 0) f.ptg = f.ptg ^ 32'h40;
        step("rand", lpc, 1'b1, f.pc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
             tgt_pool[$urandom_range(0, 3)], f.pt, f.ptg, f.idx, 1'b0);
      end else begin
        if (infl_q.size() > 4) void'(infl_q.pop_front());
        lookup("rand_idle", lpc);
      end
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
